// File: rtl/sync_w2r_gray_pkg.sv
// Shared definitions for the write-to-read pointer synchronizer:
// default address width, pointer type, FSM state type and Gray helpers.
package definitions;

    localparam int ADDRSIZE = 4;

    typedef logic [ADDRSIZE:0] ptr_t;

    // Helpers work on a 32-bit word so any pointer width up to 32 bits can
    // use them; callers zero-extend in and truncate out with size casts.
    typedef logic [31:0] word_t;

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } sync_state_t;

    function automatic word_t gray2bin(input word_t g);
        word_t b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic word_t bin2gray(input word_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic int unsigned popcount(input word_t v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) begin
                n++;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Parametrised multi-flop synchronizer chain with synchronous active-high
// reset. The first stage samples the asynchronous input directly.
module sync_chain
    import definitions::*;
#(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [STAGES];

    // Shift the incoming value one flop deeper every clock; reset empties the chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/sync_w2r_gray.sv
// Read-domain view of the asynchronous FIFO write pointer: synchronizes the
// Gray pointer, converts it to binary, derives fill/empty status against the
// local read pointer, and reports pointer advance and sticky sanity errors.
module sync_w2r_gray #(
    parameter int ADDRSIZE    = definitions::ADDRSIZE,
    parameter int SYNC_STAGES = 2,
    parameter int AE_THRESH   = 2
) (
    input  logic              rclk,
    input  logic              rrst,
    input  logic [ADDRSIZE:0] wptr_gray,
    input  logic [ADDRSIZE:0] rptr_bin,
    input  logic              err_clr,
    output logic [ADDRSIZE:0] rq_wptr_gray,
    output logic [ADDRSIZE:0] rq_wptr_bin,
    output logic [ADDRSIZE:0] rfill,
    output logic              rempty,
    output logic              ralmost_empty,
    output logic              wptr_adv,
    output logic [ADDRSIZE:0] adv_cnt,
    output logic              gray_err,
    output logic              fill_ovf
);

    import definitions::*;

    localparam int PW = ADDRSIZE + 1;

    // A pointer that has run more than a full FIFO ahead of the reader.
    localparam logic [ADDRSIZE:0] FULL_LEVEL = {1'b1, {ADDRSIZE{1'b0}}};
    localparam logic [ADDRSIZE:0] AE_LEVEL   = PW'(AE_THRESH);
    localparam logic [2:0]        PRIME_LAST = 3'(SYNC_STAGES);

    generate
        if ((SYNC_STAGES < 2) || (SYNC_STAGES > 4)) begin : g_bad_stages
            $error("sync_w2r_gray: SYNC_STAGES must be 2..4");
        end
        if ((ADDRSIZE < 1) || (ADDRSIZE > 30)) begin : g_bad_addrsize
            $error("sync_w2r_gray: ADDRSIZE must be 1..30");
        end
    endgenerate

    sync_state_t       state;
    sync_state_t       state_nxt;
    logic [2:0]        prime_cnt;
    logic [2:0]        prime_cnt_nxt;
    logic              run;

    logic [ADDRSIZE:0] prev_gray;
    logic [ADDRSIZE:0] synced_bin;
    logic [ADDRSIZE:0] step;
    logic              gray_bad;
    logic              ovf_hit;

    sync_chain #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_wptr_chain (
        .clk (rclk),
        .rst (rrst),
        .d   (wptr_gray),
        .q   (rq_wptr_gray)
    );

    // PRIME/RUN state register; reset always restarts the priming window.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            state     <= PRIME;
            prime_cnt <= '0;
        end else begin
            state     <= state_nxt;
            prime_cnt <= prime_cnt_nxt;
        end
    end

    // Stay in PRIME long enough for the chain and binary register to fill with real samples.
    always_comb begin
        state_nxt     = state;
        prime_cnt_nxt = prime_cnt;
        run           = 1'b0;
        case (state)
            PRIME: begin
                if (prime_cnt == PRIME_LAST) begin
                    state_nxt = RUN;
                end else begin
                    prime_cnt_nxt = prime_cnt + 3'd1;
                end
            end
            RUN: begin
                run = 1'b1;
            end
            default: begin
                state_nxt     = PRIME;
                prime_cnt_nxt = '0;
            end
        endcase
    end

    // Decode the synchronized pointer and compare it with the previous samples.
    always_comb begin
        synced_bin = PW'(gray2bin(32'(rq_wptr_gray)));
        step       = synced_bin - rq_wptr_bin;
        gray_bad   = popcount(32'(rq_wptr_gray ^ prev_gray)) > 1;
    end

    assign rfill         = rq_wptr_bin - rptr_bin;
    assign rempty        = (rfill == '0);
    assign ralmost_empty = (rfill <= AE_LEVEL);
    assign ovf_hit       = (rfill > FULL_LEVEL);

    // Register the binary pointer and advance info; error flags are sticky, set beats clear, and nothing can set while priming.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            rq_wptr_bin <= '0;
            prev_gray   <= '0;
            wptr_adv    <= 1'b0;
            adv_cnt     <= '0;
            gray_err    <= 1'b0;
            fill_ovf    <= 1'b0;
        end else begin
            rq_wptr_bin <= synced_bin;
            prev_gray   <= rq_wptr_gray;
            wptr_adv    <= run && (synced_bin != rq_wptr_bin);
            adv_cnt     <= (run && (synced_bin != rq_wptr_bin)) ? step : '0;
            gray_err    <= (run && gray_bad) || (gray_err && !err_clr);
            fill_ovf    <= (run && ovf_hit) || (fill_ovf && !err_clr);
        end
    end

endmodule
